demux_1_4: RTL

- Deserializer; inverse of the 4:1 output serializer in the matrix block datapath.
- Collects a stream of words arriving one per cycle, in order word0..word3, into four parallel output registers (word0 to out_1 ... word3 to out_4).
- Presents each complete group atomically with a valid/ready handshake, so the block-multiply core can load one 4-element row or column of a block per handshake.

---
 rtl/demux_1_4.sv | 131 +++++++++++++
 1 files changed

// File: rtl/demux_1_4.sv
// 1:4 word deserializer: gathers four consecutive accepted words into one parallel
// group and presents it to the consumer over a valid/ready handshake.
module demux_1_4 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             align,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic             out_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] group_count,
    output logic [1:0]       slot
);

    logic [1:0]       slot_r, slot_s;
    logic [WIDTH-1:0] stag0_r, stag1_r, stag2_r;
    logic [WIDTH-1:0] stag0_s, stag1_s, stag2_s;
    logic [WIDTH-1:0] out1_r, out2_r, out3_r, out4_r;
    logic [WIDTH-1:0] out1_s, out2_s, out3_s, out4_s;
    logic             valid_r, valid_s;
    logic             overrun_r, overrun_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             complete_s;
    logic             transfer_s;

    // Align takes priority, so a group can never complete on an align edge.
    assign complete_s = in_valid && !align && (slot_r == 2'd3);
    assign transfer_s = valid_r && out_ready;

    // Slot pointer and staging register next-state.
    always_comb begin
        slot_s  = slot_r;
        stag0_s = stag0_r;
        stag1_s = stag1_r;
        stag2_s = stag2_r;
        if (align) begin
            if (in_valid) begin
                stag0_s = in_data;
                slot_s  = 2'd1;
            end else begin
                slot_s  = 2'd0;
            end
        end else if (in_valid) begin
            slot_s = slot_r + 2'd1;
            case (slot_r)
                2'd0:    stag0_s = in_data;
                2'd1:    stag1_s = in_data;
                2'd2:    stag2_s = in_data;
                default: stag0_s = stag0_r;
            endcase
        end else begin
            slot_s = slot_r;
        end
    end

    // Output group, handshake, overrun and counter next-state.
    always_comb begin
        out1_s    = out1_r;
        out2_s    = out2_r;
        out3_s    = out3_r;
        out4_s    = out4_r;
        valid_s   = valid_r;
        overrun_s = overrun_r;
        count_s   = count_r;
        if (complete_s) begin
            out1_s  = stag0_r;
            out2_s  = stag1_r;
            out3_s  = stag2_r;
            out4_s  = in_data;
            valid_s = 1'b1;
            count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            // Overwriting a presented group that is not taken on this very edge loses it.
            if (valid_r && !out_ready) begin
                overrun_s = 1'b1;
            end else begin
                overrun_s = overrun_r;
            end
        end else if (transfer_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_r    <= 2'd0;
            stag0_r   <= {WIDTH{1'b0}};
            stag1_r   <= {WIDTH{1'b0}};
            stag2_r   <= {WIDTH{1'b0}};
            out1_r    <= {WIDTH{1'b0}};
            out2_r    <= {WIDTH{1'b0}};
            out3_r    <= {WIDTH{1'b0}};
            out4_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
        end else begin
            slot_r    <= slot_s;
            stag0_r   <= stag0_s;
            stag1_r   <= stag1_s;
            stag2_r   <= stag2_s;
            out1_r    <= out1_s;
            out2_r    <= out2_s;
            out3_r    <= out3_s;
            out4_r    <= out4_s;
            valid_r   <= valid_s;
            overrun_r <= overrun_s;
            count_r   <= count_s;
        end
    end

    assign out_1       = out1_r;
    assign out_2       = out2_r;
    assign out_3       = out3_r;
    assign out_4       = out4_r;
    assign out_valid   = valid_r;
    assign overrun     = overrun_r;
    assign group_count = count_r;
    assign slot        = slot_r;

endmodule
